cache_ctrl_burst: RTL
=====================

// Module: cache_ctrl_burst
// PURPOSE
//  Parametrised cache controller FSM; successor to the single-word controller. Sits between
//  CPU strobe/RW and the cache tag/data arrays + main memory. Adds an internal wait counter,
//  multi-word line refill (burst), WordIdx sequencing and optional write-allocate mode.
//  Write-through policy in all modes; one outstanding CPU request at a time.
// PARAMETERS
//  WAIT_CYCLES     4  memory latency in cycles after MStrobe pulse (>=1, <=255)
//  WORDS_PER_LINE  4  words per cache line filled on a miss (power of 2, >=1)
//  WRITE_ALLOCATE  0  0: write miss updates memory only; 1: write miss refills line, then writes word
//  IDX_W           max(1,$clog2(WORDS_PER_LINE)) width of WordIdx (localparam, derived)
// PORTS
//  clk      in   1      single clock, all state on rising edge
//  reset    in   1      asynchronous, active-low; 0 forces IDLE immediately
//  Strobe   in   1      CPU request valid; sampled only in IDLE
//  DRW      in   1      1 = write, 0 = read; sampled with Strobe
//  M        in   1      tag match for current address
//  V        in   1      valid bit for current line
//  DReady   out  1      request complete, 1-cycle pulse
//  W        out  1      cache data/tag array write enable
//  MStrobe  out  1      memory request, 1-cycle pulse
//  MRW      out  1      memory direction, 1 = write, 0 = read
//  RSel     out  1      CPU read mux: 1 = memory data, 0 = cache data
//  WSel     out  1      cache write source: 1 = memory data, 0 = CPU data
//  WordIdx  out  IDX_W  word offset within line for refill writes
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, WordIdx=0, hit/alloc flags=0; all outputs 0.
//  Outputs are state decodes except DReady in READ (combinational on M&V).
//  States / transitions:
//   IDLE  : Strobe&~DRW -> READ; Strobe&DRW -> WRITE; else stay. Strobe ignored elsewhere.
//   READ  : M&V -> DReady=1, RSel=0, -> IDLE. Else -> RMISS.
//   WRITE : latch hit=M&V, alloc=~hit&WRITE_ALLOCATE; -> WSTRB.
//   RMISS : MStrobe=1, MRW=0; load counter=WAIT_CYCLES-1; WordIdx=0; -> RWAIT.
//   RWAIT : decrement; at 0 -> RFILL. Exactly WAIT_CYCLES cycles in RWAIT.
//   RFILL : W=1, WSel=1, RSel=1; one word per cycle, WordIdx 0..WORDS_PER_LINE-1.
//           Last word: if alloc -> WDONE (no DReady); else DReady=1 -> IDLE.
//   WSTRB : MStrobe=1, MRW=1; load counter=WAIT_CYCLES-1; -> WWAIT.
//   WWAIT : MRW=1; decrement; at 0: alloc -> RMISS, else -> WDONE.
//   WDONE : DReady=1; W=hit|alloc, WSel=0; clear hit/alloc; -> IDLE.
//  Latency (Strobe sampled in cycle 0): read hit DReady cycle 1;
//   read miss DReady cycle 3+WAIT_CYCLES+WORDS_PER_LINE-1; write (no alloc) DReady cycle 3+WAIT_CYCLES.
//  Boundaries:
//   WORDS_PER_LINE=1: RFILL lasts 1 cycle, WordIdx stays 0.
//   WAIT_CYCLES=1: RWAIT/WWAIT last 1 cycle.
//   WordIdx wraps to 0 after last refill word; holds 0 outside RFILL.
//   M/V changing mid-op ignored after READ/WRITE decision (hit latched).
//   reset low mid-op: immediate IDLE, no further MStrobe/W/DReady; pending request dropped.
//   Illegal state encodings -> IDLE, outputs 0.
// TESTING (WAIT_CYCLES=4, WORDS_PER_LINE=4 unless stated)
//  1 Read hit: Strobe=1,DRW=0,M=V=1 cyc0 -> DReady=1 cyc1 only, no MStrobe, W=0.
//  2 Read miss: M=0 -> MStrobe cyc2 MRW=0; W=WSel=RSel=1 cyc7..10, WordIdx 0,1,2,3; DReady cyc10.
//  3 Write hit, WRITE_ALLOCATE=0: MStrobe+MRW cyc2; DReady, W=1, WSel=0 cyc7.
//  4 Write miss: alloc=0 -> DReady cyc7, W=0; alloc=1 -> refill cyc12..15, DReady+W=1,WSel=0 cyc16.
//  5 reset=0 during RWAIT -> all outputs 0 same cycle; after release Strobe read hit -> DReady 1 cyc later.
//  6 WORDS_PER_LINE=1, WAIT_CYCLES=1 read miss: MStrobe cyc2, RFILL cyc4 WordIdx=0, DReady cyc4.

Source files
------------

// File: rtl/cache_ctrl_burst.sv
// Write-through cache controller with multi-word line refill, an internal memory wait
// counter and optional write-allocate on write misses. One CPU request is handled at a time.
module cache_ctrl_burst #(
  parameter  int WAIT_CYCLES    = 4,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int WRITE_ALLOCATE = 0,
  localparam int IDX_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Strobe,
  input  logic             DRW,
  input  logic             M,
  input  logic             V,
  output logic             DReady,
  output logic             W,
  output logic             MStrobe,
  output logic             MRW,
  output logic             RSel,
  output logic             WSel,
  output logic [IDX_W-1:0] WordIdx
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    READ  = 4'd1,
    WRITE = 4'd2,
    RMISS = 4'd3,
    RWAIT = 4'd4,
    RFILL = 4'd5,
    WSTRB = 4'd6,
    WWAIT = 4'd7,
    WDONE = 4'd8
  } state_t;

  localparam logic [7:0]       CNT_LOAD = 8'(WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic             ALLOC_EN = (WRITE_ALLOCATE != 0);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic             alloc_q, alloc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    alloc_d = alloc_q;
    case (state_q)
      IDLE:  if (Strobe) state_d = DRW ? WRITE : READ;
      READ:  state_d = (M & V) ? IDLE : RMISS;
      WRITE: begin
        // Hit/allocate decision is frozen here; later M/V activity is irrelevant.
        hit_d   = M & V;
        alloc_d = ~(M & V) & ALLOC_EN;
        state_d = WSTRB;
      end
      RMISS: begin
        cnt_d   = CNT_LOAD;
        idx_d   = '0;
        state_d = RWAIT;
      end
      RWAIT: begin
        if (cnt_q == 8'd0) state_d = RFILL;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RFILL: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = alloc_q ? WDONE : IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WSTRB: begin
        cnt_d   = CNT_LOAD;
        state_d = WWAIT;
      end
      WWAIT: begin
        if (cnt_q == 8'd0) state_d = alloc_q ? RMISS : WDONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      WDONE: begin
        hit_d   = 1'b0;
        alloc_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        idx_d   = '0;
        hit_d   = 1'b0;
        alloc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      alloc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      alloc_q <= alloc_d;
    end
  end

  // Outputs decode the current state; only the read-hit DReady looks at live M/V.
  always_comb begin
    DReady  = 1'b0;
    W       = 1'b0;
    MStrobe = 1'b0;
    MRW     = 1'b0;
    RSel    = 1'b0;
    WSel    = 1'b0;
    WordIdx = '0;
    case (state_q)
      READ:  DReady = M & V;
      RMISS: MStrobe = 1'b1;
      RFILL: begin
        W       = 1'b1;
        WSel    = 1'b1;
        RSel    = 1'b1;
        WordIdx = idx_q;
        DReady  = (idx_q == IDX_LAST) & ~alloc_q;
      end
      WSTRB: begin
        MStrobe = 1'b1;
        MRW     = 1'b1;
      end
      WWAIT: MRW = 1'b1;
      WDONE: begin
        DReady = 1'b1;
        W      = hit_q | alloc_q;
      end
      default: ;
    endcase
  end

endmodule
